// File: rtl/step_fsm.sv
// Button-driven state stepper: synchronised, edge-detected next/prev buttons
// move a state index forward/backward in circular or saturating mode.

module step_fsm_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic button_n,
   output logic press
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] valid_q;
   logic                   hist_q;
   logic                   armed_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // valid_q tracks when real button samples reach the synchroniser output;
   // presses are armed only after a genuine idle-high level has been seen,
   // so a button held low through reset release never produces a step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= '1;
         valid_q <= '0;
         hist_q  <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], button_n};
         valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
         hist_q  <= sync_out;
         if (valid_q[SYNC_STAGES-1] && sync_out) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign press = armed_q & hist_q & ~sync_out;

endmodule

module step_fsm #(
   parameter int NUM_STATES  = 4,
   parameter int LED_STATE   = NUM_STATES - 1,
   parameter int SYNC_STAGES = 2,
   parameter int STATE_W     = $clog2(NUM_STATES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  button_next_n,
   input  logic                  button_prev_n,
   input  logic                  wrap_en,
   output logic [STATE_W-1:0]    state,
   output logic                  led,
   output logic [NUM_STATES-1:0] leds,
   output logic                  wrap_pulse
);

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_INC,
      ACT_DEC,
      ACT_WRAP_TO_FIRST,
      ACT_WRAP_TO_LAST,
      ACT_RECOVER
   } action_t;

   localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
   localparam logic [STATE_W-1:0] LED_INDEX  = STATE_W'(LED_STATE);
   localparam bit                 HAS_GAP    = (NUM_STATES != (1 << STATE_W));

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic               wrap_q;
   logic               wrap_d;
   logic               press_next;
   logic               press_prev;
   logic               out_of_range;
   action_t            action;

   step_fsm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_next (
      .clock    (clock),
      .reset    (reset),
      .button_n (button_next_n),
      .press    (press_next)
   );

   step_fsm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_prev (
      .clock    (clock),
      .reset    (reset),
      .button_n (button_prev_n),
      .press    (press_prev)
   );

   // Unused encodings only exist when NUM_STATES is not a power of two.
   generate
      if (HAS_GAP) begin : g_gap
         assign out_of_range = (state_q > LAST_STATE);
      end else begin : g_no_gap
         assign out_of_range = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

   // Decide the step, then apply it; simultaneous presses cancel out.
   always_comb begin
      action  = ACT_HOLD;
      state_d = state_q;
      wrap_d  = 1'b0;

      if (out_of_range) begin
         action = ACT_RECOVER;
      end else if (press_next && !press_prev) begin
         if (state_q != LAST_STATE) begin
            action = ACT_INC;
         end else if (wrap_en) begin
            action = ACT_WRAP_TO_FIRST;
         end
      end else if (press_prev && !press_next) begin
         if (state_q != '0) begin
            action = ACT_DEC;
         end else if (wrap_en) begin
            action = ACT_WRAP_TO_LAST;
         end
      end

      case (action)
         ACT_INC:           state_d = state_q + 1'b1;
         ACT_DEC:           state_d = state_q - 1'b1;
         ACT_WRAP_TO_FIRST: begin
            state_d = '0;
            wrap_d  = 1'b1;
         end
         ACT_WRAP_TO_LAST:  begin
            state_d = LAST_STATE;
            wrap_d  = 1'b1;
         end
         ACT_RECOVER:       state_d = '0;
         default:           state_d = state_q;
      endcase
   end

   generate
      for (genvar i = 0; i < NUM_STATES; i++) begin : g_leds
         assign leds[i] = (state_q == STATE_W'(i));
      end
   endgenerate

   assign state      = state_q;
   assign led        = (state_q == LED_INDEX);
   assign wrap_pulse = wrap_q;

endmodule
